bcd_counter_ndigit: RTL

//  Parametrised multi-digit BCD counter. Successor to the single-digit 0-9 counter.

---
 rtl/bcd_counter_ndigit_pkg.sv | 22 ++
 rtl/bcd_counter_ndigit_if.sv | 24 ++
 rtl/bcd_counter_ndigit_digit_cell.sv | 37 +++
 rtl/bcd_counter_ndigit.sv | 73 +++++++
 4 files changed

// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared BCD nibble type, decade limits and nibble helpers for the N-digit counter.
// Pure definitions: no latency; no flow control.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Codes 10..15 are not decimal digits; they collapse to zero on load.
    function automatic bcd_t bcd_sanitize(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MIN : v;
    endfunction

    function automatic bcd_t bcd_step(input bcd_t v, input logic up);
        bcd_t r;
        if (up) r = (v >= BCD_MAX) ? BCD_MIN : v + 4'd1;
        else    r = (v == BCD_MIN || v > BCD_MAX) ? BCD_MAX : v - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_if.sv
// Control/status bundle of the N-digit BCD counter.
// Wires only: no latency; no backpressure.
interface bcd_counter_ndigit_if #(
    parameter int DIGITS = 4
);
    logic                  pause;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  tc;
    logic                  wrap;
    logic                  ld_err;

    modport master (
        output pause, up, load, d,
        input  q, tc, wrap, ld_err
    );

    modport slave (
        input  pause, up, load, d,
        output q, tc, wrap, ld_err
    );
endinterface

// File: rtl/bcd_counter_ndigit_digit_cell.sv
// One BCD decade: sanitising parallel load, or +/-1 step when enabled and carried into.
// Latency: 1 clk to q_o; no backpressure.
module bcd_digit_cell
    import bcd_counter_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic up,
    input  logic ld,
    input  bcd_t d_i,
    input  logic ci,
    output bcd_t q_o,
    output logic co
);

    bcd_t q_nxt;

    always_comb begin
        q_nxt = q_o;
        if (ld)
            q_nxt = bcd_sanitize(d_i);
        else if (en && ci)
            q_nxt = bcd_step(q_o, up);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            q_o <= BCD_MIN;
        else
            q_o <= q_nxt;
    end

    // Carry when counting up, borrow when counting down.
    assign co = up ? (q_o == BCD_MAX) : (q_o == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-decade up/down BCD counter with load, pause, wrap/saturate and status flags.
// Latency: 1 clk to q, wrap, ld_err (tc combinational); no backpressure.
module bcd_counter_ndigit
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr_n,
    bcd_counter_ndigit_if.slave  bus
);

    logic [DIGITS-1:0]   co;
    logic [DIGITS-1:0]   ci;
    logic [4*DIGITS-1:0] q_int;
    logic                at_term;
    logic                cnt_en;
    logic                d_bad;
    logic                wrap_q;
    logic                ld_err_q;

    // At terminal every decade is presenting its carry/borrow at once.
    assign at_term = &co;
    assign cnt_en  = ~bus.pause & ~(SATURATE & at_term);

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign ci[k] = 1'b1;
            end else begin : g_upper
                assign ci[k] = ci[k-1] & co[k-1];
            end

            bcd_digit_cell u_cell (
                .clk   (clk),
                .clr_n (clr_n),
                .en    (cnt_en),
                .up    (bus.up),
                .ld    (bus.load),
                .d_i   (bus.d[4*k +: 4]),
                .ci    (ci[k]),
                .q_o   (q_int[4*k +: 4]),
                .co    (co[k])
            );
        end
    endgenerate

    always_comb begin
        d_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.d[4*i +: 4] > BCD_MAX)
                d_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= bus.load & d_bad;
            wrap_q   <= ~bus.load & ~bus.pause & at_term & ~SATURATE;
        end
    end

    assign bus.q      = q_int;
    assign bus.tc     = at_term & ~bus.pause;
    assign bus.wrap   = wrap_q;
    assign bus.ld_err = ld_err_q;

endmodule
